collect: RTL
============

# collect

Downstream of the reorder stage. Consumes its tagged, index-ordered stream of `{index, data}` words and deserializes each group of N words into one N-wide parallel vector for the next compute stage. Each word is placed into the vector slot named by its index tag. A completed vector is presented on a single strobe/ready output. An optional checker flags tags that break the expected 0..N-1 sequence.

## Interface
- `W`, default 8: data width per element.
- `N`, default 2: elements per vector. Must be ≥ 2. `IW = $clog2(N)`.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `s_stb`, in, 1: input word valid.
- `s_dat`, in, IW+W: input word. `[IW+W-1:W]` is the index tag, `[W-1:0]` is the data.
- `s_rdy`, out, 1: input ready.
- `m_stb`, out, 1: output vector valid.
- `m_dat`, out, N*W: output vector. Slot k is `m_dat[k*W +: W]`.
- `m_rdy`, in, 1: output ready.
- `err`, out, 1: sticky sequence error. Constant 0 unless the check is compiled in.

## Operation
- State machine has two states: FILL and HOLD. Reset state is FILL.
- A counter `cnt` (IW bits) tracks words accepted in the current vector. Reset value is 0.
- **FILL state:**
  - `s_rdy`=1, `m_stb`=0.
  - On `s_stb & s_rdy`: if tag < N, write data into slot `tag`. If tag ≥ N, no slot is written.
  - On the same accept, if `cnt == N-1`: `cnt` goes to 0 and the state goes to HOLD. Otherwise `cnt` increments by 1.
- **HOLD state:**
  - `s_rdy`=0, `m_stb`=1.
  - `m_dat` is stable while HOLD is held.
  - On `m_rdy`, the state goes to FILL.
- Slots are not cleared between vectors. A slot that receives no write keeps its previous value.
- The tag alone decides slot placement. `cnt` decides only vector completion: exactly N accepted words close a vector.
- **Reset mid-operation:**
  - State returns to FILL, `cnt` to 0, `m_dat` to 0, `err` to 0.
  - A partially filled vector is discarded.
  - A pending HOLD vector is dropped without handshake.

## Timing
- Reset values: `s_rdy`=1, `m_stb`=0, `m_dat`=0, `err`=0.
- `s_rdy` and `m_stb` are decoded only from the state register. There are no combinational paths from `s_stb` or `m_rdy`.
- Latency: `m_stb` rises on the cycle after the N-th word is accepted.
- Data accepted on cycle t is visible on `m_dat` at cycle t+1.
- In HOLD with `m_rdy`=1 on cycle t: `s_rdy`=1 and `m_stb`=0 from cycle t+1.
- Throughput: one vector per N+1 cycles at best (N fill cycles plus 1 hold cycle). No overlap of fill and hold.
- Handshake rules:
  - Upstream must hold `s_dat` stable while `s_stb` is high and `s_rdy` is low.
  - `m_stb`, once raised, stays high until `m_rdy`.
- `err` updates on the cycle after the offending accept.

## Configuration
- Macro: `COLLECT_CHECK_EN`.
- **Defined:**
  - On every accept, the tag is compared against `cnt`.
  - If tag ≠ `cnt` or tag ≥ N, `err` is set and stays 1 until `rst`.
  - The offending word is still consumed and counted. It is written only if tag < N.
- **Undefined:**
  - No compare logic is built and `err` is tied to 0.
  - Placement and counting behaviour is identical to the defined case.

## Test plan
- **Basic fill (N=2, W=8):**
  - Stimulus: `{0,8'h11}` then `{1,8'h22}`, with `m_rdy`=1.
  - Required: `m_stb` for 1 cycle with `m_dat`=16'h2211; `err`=0.
- **Backpressure:**
  - Stimulus: same words, with `m_rdy`=0 for 5 cycles.
  - Required: `m_stb` is held 5 cycles, `m_dat` stays stable, `s_rdy`=0 throughout; one vector is accepted when `m_rdy` rises.
- **Back-to-back vectors (N=4):**
  - Stimulus: tags 0..3 with data 1..4, then 5..8, with `m_rdy`=1.
  - Required: outputs 32'h04030201 then 32'h08070605, spaced 5 cycles apart.
- **Out-of-order tags (N=2, check defined):**
  - Stimulus: `{1,8'hAA}` then `{0,8'hBB}`.
  - Required: `m_dat`=16'hAABB; `err`=1 from the cycle after the first accept, and it stays set for the next clean vector.
- **Out-of-range tag (N=3):**
  - Stimulus: tags 0,3,2 with data 1,2,3.
  - Required: slot1 keeps its previous value (0 after reset); `m_dat`=24'h030001; `err`=1 (check defined) or 0 (undefined).
- **Reset mid-fill:**
  - Stimulus: assert `rst` after 1 of 2 words.
  - Required: `m_dat`=0 and `cnt`=0; the next 2 words produce exactly one vector.

Source files
------------

// File: rtl/collect.sv
// collect - deserializes N tagged words into one N-wide vector; tag picks the slot.
// Optional tag-sequence checker compiled in with `define COLLECT_CHECK_EN.
module collect #(
  parameter int W = 8,
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_stb,
  input  logic [IW+W-1:0]   s_dat,
  output logic              s_rdy,
  output logic              m_stb,
  output logic [N*W-1:0]    m_dat,
  input  logic              m_rdy,
  output logic              err
);

  typedef enum logic {FILL, HOLD} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [N*W-1:0]    dat_q, dat_d;
  logic              accept;
  logic [IW-1:0]     tag;
  logic [W-1:0]      data;
  logic              in_range;

  assign tag      = s_dat[IW+W-1:W];
  assign data     = s_dat[W-1:0];
  assign in_range = 32'(tag) < N;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    s_rdy   = 1'b0;
    m_stb   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      FILL: begin
        s_rdy = 1'b1;
        if (s_stb) begin
          accept = 1'b1;
          // Out-of-range tags match no slot, so nothing is written.
          for (int k = 0; k < N; k++) begin
            if (32'(tag) == k) dat_d[k*W +: W] = data;
          end
          if (cnt_q == IW'(N-1)) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        m_stb = 1'b1;
        if (m_rdy) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
    end
  end

  assign m_dat = dat_q;

`ifdef COLLECT_CHECK_EN
  logic err_q, err_d;

  // Sticky: any tag that is out of range or out of sequence latches until reset.
  always_comb begin
    err_d = err_q;
    if (accept && ((tag != cnt_q) || !in_range)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
